// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: the fetch stage drives the request and address,
// the memory returns a word with a one-cycle ready strobe.
interface fetch_unit_if #(
  parameter int unsigned width = 32
);
  logic             mem_req;
  logic [width-1:0] mem_addr;
  logic             mem_ready;
  logic [width-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory read per start and latches
// the returned word. The next sequential PC comes from the external incrementer.
module fetch_unit #(
  parameter int unsigned      width      = 32,
  parameter logic [width-1:0] reset_addr = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             redirect,
  input  logic [width-1:0] redirect_addr,
  output logic [width-1:0] inc_in,
  input  logic [width-1:0] inc_out,
  fetch_unit_if.master     mem,
  output logic [width-1:0] pc,
  output logic [width-1:0] instr,
  output logic             instr_valid,
  output logic             busy
);

  typedef enum logic [1:0] {st_idle, st_req, st_done} state_t;

  state_t           state_q, state_d;
  logic             flush_q, flush_d;
  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] instr_q, instr_d;
  logic [width-1:0] addr_q, addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= st_idle;
      flush_q <= 1'b0;
      pc_q    <= reset_addr;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    unique case (state_q)
      st_idle: begin
        if (start) begin
          state_d = st_req;
          addr_d  = redirect ? redirect_addr : pc_q;
        end
      end
      st_req: begin
        // A flush cycle drops whatever the memory returns and re-issues at the new PC.
        if (flush_q) begin
          addr_d  = pc_q;
          flush_d = 1'b0;
        end else if (mem.mem_ready && !redirect) begin
          instr_d = mem.mem_rdata;
          pc_d    = inc_out;
          state_d = st_done;
        end
      end
      st_done: state_d = st_idle;
      default: state_d = st_idle;
    endcase
    if (redirect) begin
      pc_d = redirect_addr;
      if (state_q == st_req) flush_d = 1'b1;
    end
  end

  always_comb begin
    mem.mem_req  = (state_q == st_req);
    mem.mem_addr = addr_q;
    busy         = (state_q == st_req);
    instr_valid  = (state_q == st_done);
    pc           = pc_q;
    inc_in       = pc_q;
    instr        = instr_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a driver plays control unit and memory, a
// reference PC model predicts each fetched word, and a monitor checks every instr_valid.
module tb_fetch_unit;
  localparam logic [31:0] ResetAddr = 32'h100;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, redirect;
  logic [31:0] redirect_addr, inc_in, inc_out, pc, instr;
  logic        instr_valid, busy;
  logic        rdata_fixed;
  logic [31:0] rdata_val;
  logic [31:0] model_pc;
  int          ncmp = 0;
  int          nfail = 0;
  exp_t        exp_q[$];

  fetch_unit_if #(.width(32)) mif ();

  fetch_unit #(
    .width     (32),
    .reset_addr(ResetAddr)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .inc_in       (inc_in),
    .inc_out      (inc_out),
    .mem          (mif),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed hash of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  assign inc_out       = inc_in + 32'd1;
  assign mif.mem_rdata = rdata_fixed ? rdata_val : memf(mif.mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && instr_valid) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_instr_valid: got instr %h pc %h, expected no fetch", instr, pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr", instr, e.instr);
        check("pc_after_fetch", pc, e.pc);
      end
    end
  end

  // One complete fetch starting from IDLE; optional redirect with start, mid-REQ
  // redirect at REQ cycle redir_at (-1 = none), and random activity during DONE.
  task automatic fetch(input int waits, input int redir_at, input logic [31:0] raddr,
                       input bit redir_start, input logic [31:0] saddr, input bit done_rand);
    logic [31:0] exp_addr;
    int          w;
    int          i;
    start = 1'b1;
    if (redir_start) begin
      redirect      = 1'b1;
      redirect_addr = saddr;
      model_pc      = saddr;
    end
    exp_addr = model_pc;
    step();
    start    = 1'b0;
    redirect = 1'b0;
    w = waits;
    i = 0;
    while (1) begin
      check("mem_req_in_req", {31'd0, mif.mem_req}, 32'd1);
      check("busy_in_req", {31'd0, busy}, 32'd1);
      check("mem_addr", mif.mem_addr, exp_addr);
      if (i == redir_at) begin
        redirect      = 1'b1;
        redirect_addr = raddr;
        model_pc      = raddr;
        mif.mem_ready = (w == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        redirect      = 1'b0;
        check("mem_req_flush", {31'd0, mif.mem_req}, 32'd1);
        mif.mem_ready = 1'($urandom_range(0, 1));
        step();
        mif.mem_ready = 1'b0;
        exp_addr = model_pc;
        w = $urandom_range(0, 3);
      end else if (w == 0) begin
        mif.mem_ready = 1'b1;
        exp_q.push_back('{memf(model_pc), model_pc + 32'd1});
        model_pc = model_pc + 32'd1;
        step();
        mif.mem_ready = 1'b0;
        break;
      end else begin
        w--;
        step();
      end
      i++;
    end
    check("instr_valid_done", {31'd0, instr_valid}, 32'd1);
    if (done_rand) begin
      start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        redirect      = 1'b1;
        redirect_addr = $urandom;
        model_pc      = redirect_addr;
      end
    end
    step();
    start    = 1'b0;
    redirect = 1'b0;
    check("mem_req_idle", {31'd0, mif.mem_req}, 32'd0);
    check("instr_valid_idle", {31'd0, instr_valid}, 32'd0);
    check("pc_idle", pc, model_pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    mif.mem_ready = 1'b0;
    rdata_fixed = 1'b0;
    rdata_val = '0;
    model_pc = ResetAddr;
    step();
    step();
    check("reset_pc", pc, ResetAddr);
    check("reset_mem_req", {31'd0, mif.mem_req}, 32'd0);
    check("reset_instr", instr, 32'd0);
    check("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_mem_addr", mif.mem_addr, 32'd0);
    reset = 1'b0;
    step();

    // Basic zero-wait fetch of a known word.
    start = 1'b1;
    step();
    start = 1'b0;
    check("basic_mem_req", {31'd0, mif.mem_req}, 32'd1);
    check("basic_mem_addr", mif.mem_addr, 32'h100);
    rdata_fixed = 1'b1;
    rdata_val = 32'hDEADBEEF;
    mif.mem_ready = 1'b1;
    exp_q.push_back('{32'hDEADBEEF, 32'h101});
    model_pc = 32'h101;
    step();
    mif.mem_ready = 1'b0;
    rdata_fixed = 1'b0;
    check("basic_valid", {31'd0, instr_valid}, 32'd1);
    step();
    check("basic_valid_pulse", {31'd0, instr_valid}, 32'd0);

    fetch(4, -1, 32'd0, 1'b0, 32'd0, 1'b0);

    // Redirect mid-fetch: stale 0x1111 discarded, re-issue at 0x40 returns 0x2222.
    start = 1'b1;
    step();
    start = 1'b0;
    check("redir_mem_addr_before", mif.mem_addr, model_pc);
    redirect = 1'b1;
    redirect_addr = 32'h40;
    step();
    redirect = 1'b0;
    rdata_fixed = 1'b1;
    rdata_val = 32'h1111;
    mif.mem_ready = 1'b1;
    step();
    check("redir_reissue_addr", mif.mem_addr, 32'h40);
    check("redir_mem_req", {31'd0, mif.mem_req}, 32'd1);
    rdata_val = 32'h2222;
    exp_q.push_back('{32'h2222, 32'h41});
    model_pc = 32'h41;
    step();
    mif.mem_ready = 1'b0;
    rdata_fixed = 1'b0;
    check("redir_valid", {31'd0, instr_valid}, 32'd1);
    step();

    // PC wrap at the top of the address space.
    fetch(0, -1, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    check("wrap_pc", pc, 32'd0);

    // Reset while a request is outstanding; a stale response must be ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_pc = ResetAddr;
    check("rst_req_mem_req", {31'd0, mif.mem_req}, 32'd0);
    check("rst_req_pc", pc, ResetAddr);
    check("rst_req_busy", {31'd0, busy}, 32'd0);
    mif.mem_ready = 1'b1;
    step();
    step();
    mif.mem_ready = 1'b0;
    check("rst_req_no_valid", {31'd0, instr_valid}, 32'd0);

    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 3) == 0) begin
          redirect = 1'b1;
          redirect_addr = $urandom;
          model_pc = redirect_addr;
        end
        step();
        redirect = 1'b0;
      end
      fetch($urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
            $urandom, 1'($urandom_range(0, 3) == 0), $urandom, 1'b1);
    end

    step();
    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
